phaser_tap_ctrl: RTL and testbench
==================================

// Module: phaser_tap_ctrl
// PURPOSE
//  Sequences fine/coarse delay-tap steps on the per-byte-lane PHASER_IN/PHASER_OUT of the DDR PHY.
//  Accepts one step request at a time from calibration logic and emits single-cycle enable/inc pulses.
//  Waits a settle interval after each pulse, then reports completion, steps done and any error.
//  Keeps a shadow tap counter per lane/target for readback and limit checking.
// PARAMETERS
//  NUM_LANES      4   byte lanes controlled; LW = $clog2(NUM_LANES), min 1
//  SETTLE_CYCLES  8   idle cycles after each pulse before next pulse/sample (>=1)
//  FINE_MAX       63  highest legal fine tap (PHASER_IN and PHASER_OUT)
//  COARSE_MAX     7   highest legal PHASER_OUT coarse tap
// PORTS
//  CLK               in   1      sole clock (PHY fabric clock)
//  RST               in   1      synchronous, active-high reset
//  REQ_VALID         in   1      step request valid
//  REQ_READY         out  1      high only in IDLE
//  REQ_LANE          in   LW     target byte lane
//  REQ_TARGET        in   2      0=PI fine, 1=PO fine, 2=PO coarse, 3=illegal
//  REQ_INC           in   1      1=increment, 0=decrement
//  REQ_STEPS         in   6      tap steps to issue (0 legal)
//  DONE              out  1      one-cycle completion pulse
//  DONE_STEPS        out  6      steps actually issued; held until next DONE
//  DONE_ERR          out  1      limit/overflow/illegal; held until next DONE
//  PI_FINEENABLE     out  N      per-lane PHASER_IN FINEENABLE pulse
//  PI_FINEINC        out  N      per-lane PHASER_IN FINEINC
//  PO_FINEENABLE     out  N      per-lane PHASER_OUT FINEENABLE pulse
//  PO_FINEINC        out  N      per-lane PHASER_OUT FINEINC
//  PO_COARSEENABLE   out  N      per-lane PHASER_OUT COARSEENABLE pulse
//  PO_COARSEINC      out  N      per-lane PHASER_OUT COARSEINC
//  PI_FINEOVERFLOW   in   N      per-lane PHASER_IN FINEOVERFLOW
//  PO_FINEOVERFLOW   in   N      per-lane PHASER_OUT FINEOVERFLOW
//  PO_COARSEOVERFLOW in   N      per-lane PHASER_OUT COARSEOVERFLOW
//  RD_LANE           in   LW     readback lane select
//  RD_PI_FINE        out  6      shadow PI fine tap of RD_LANE (combinational)
//  RD_PO_FINE        out  6      shadow PO fine tap of RD_LANE (combinational)
//  RD_PO_COARSE      out  3      shadow PO coarse tap of RD_LANE (combinational)
// BEHAVIOUR
//  Reset: FSM=IDLE; all enable/inc outputs, DONE, DONE_STEPS, DONE_ERR = 0; all shadow taps = 0.
//  RST mid-operation: pulses drop at the same edge; no DONE issued; request discarded.
//  FSM states IDLE, CHECK, PULSE, SETTLE, FIN:
//   IDLE: REQ_READY=1; REQ_VALID&&REQ_READY latches lane/target/inc/steps and enters CHECK; issued=0.
//   CHECK: TARGET==3 -> err, FIN. issued==steps -> FIN. Inc at max or dec at 0 -> err, FIN.
//    Otherwise -> PULSE.
//   PULSE: exactly one cycle; ENABLE and INC of the selected lane/target driven.
//    INC mirrors REQ_INC during PULSE, 0 otherwise. Shadow tap +/-1; issued+1. -> SETTLE.
//   SETTLE: SETTLE_CYCLES cycles with all enables low.
//    Selected lane's OVERFLOW high in any SETTLE cycle -> err, FIN. Otherwise -> CHECK.
//   FIN: DONE=1 for one cycle; DONE_STEPS=issued; DONE_ERR=err. -> IDLE.
//  Latency: REQ accept -> DONE = 2 + steps*(2+SETTLE_CYCLES) cycles (2 for steps=0, no pulses).
//  Only one enable bit across all 3N enable outputs is ever high, for exactly one cycle.
//  Shadow taps never wrap; a pulse that would exceed the limit is never issued.
//  OVERFLOW inputs of non-selected lanes and outside SETTLE are ignored.
//  REQ_* inputs are ignored while REQ_READY=0.
// TESTING
//  T1 reset, lane1 PI fine inc 5 -> 5 PULSEs 10 cycles apart on PI_FINEENABLE[1];
//     DONE at cycle 52; STEPS=5; ERR=0; RD_PI_FINE(lane1)=5.
//  T2 lane0 PO coarse: inc 9 -> 7 pulses then DONE, STEPS=7, ERR=1;
//     then dec 2 -> RD_PO_COARSE=5, ERR=0.
//  T3 lane2 PO fine inc 4; PO_FINEOVERFLOW[2] high in 2nd SETTLE -> DONE, STEPS=2, ERR=1;
//     no 3rd pulse.
//  T4 steps=0 -> DONE 2 cycles after accept, STEPS=0, ERR=0, no enables;
//     TARGET=3 -> ERR=1, STEPS=0.
//  T5 RST asserted during 3rd SETTLE of an 8-step request -> no DONE; all outputs 0;
//     shadows 0; REQ_READY=1 next cycle.
//  T6 REQ_VALID held high with changing fields while busy -> ignored;
//     accepted only when REQ_READY=1; one-hot enable assertion checked throughout.

Source files
------------

// File: rtl/phaser_tap_ctrl.sv
// phaser_tap_ctrl: steps PHASER_IN / PHASER_OUT delay taps one pulse at a time
// for a set of DDR byte lanes, waits for each step to settle, watches the
// phaser overflow flags, and keeps a shadow copy of every tap for readback.
module phaser_tap_ctrl #(
    parameter int NUM_LANES     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int FINE_MAX      = 63,
    parameter int COARSE_MAX    = 7,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LW-1:0]        req_lane,
    input  logic [1:0]           req_target,
    input  logic                 req_inc,
    input  logic [5:0]           req_steps,
    output logic                 done,
    output logic [5:0]           done_steps,
    output logic                 done_err,
    output logic [NUM_LANES-1:0] pi_fineenable,
    output logic [NUM_LANES-1:0] pi_fineinc,
    output logic [NUM_LANES-1:0] po_fineenable,
    output logic [NUM_LANES-1:0] po_fineinc,
    output logic [NUM_LANES-1:0] po_coarseenable,
    output logic [NUM_LANES-1:0] po_coarseinc,
    input  logic [NUM_LANES-1:0] pi_fineoverflow,
    input  logic [NUM_LANES-1:0] po_fineoverflow,
    input  logic [NUM_LANES-1:0] po_coarseoverflow,
    input  logic [LW-1:0]        rd_lane,
    output logic [5:0]           rd_pi_fine,
    output logic [5:0]           rd_po_fine,
    output logic [2:0]           rd_po_coarse
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [5:0]    FINE_LIM    = 6'(FINE_MAX);
    localparam logic [5:0]    COARSE_LIM  = 6'(COARSE_MAX);

    typedef enum logic [2:0] {IDLE, CHECK, PULSE, SETTLE, FIN} state_t;

    state_t state, state_next;

    // Latched request and progress of the current step sequence
    logic [LW-1:0] lane;
    logic [1:0]    target;
    logic          inc;
    logic [5:0]    steps;
    logic [5:0]    issued;
    logic          err;
    logic [SW-1:0] settle_cnt;

    // Shadow tap counters, one per lane and target
    logic [5:0] pi_fine   [NUM_LANES];
    logic [5:0] po_fine   [NUM_LANES];
    logic [2:0] po_coarse [NUM_LANES];

    logic [5:0]           cur_tap;
    logic [5:0]           cur_lim;
    logic                 sel_ovf;
    logic                 at_limit;
    logic                 err_set;
    logic [NUM_LANES-1:0] lane_onehot;

    assign req_ready    = (state == IDLE);
    assign done         = (state == FIN);
    assign rd_pi_fine   = pi_fine[rd_lane];
    assign rd_po_fine   = po_fine[rd_lane];
    assign rd_po_coarse = po_coarse[rd_lane];

    // Current tap, its legal limit and its overflow flag for the latched lane/target
    always_comb begin
        cur_tap = '0;
        cur_lim = FINE_LIM;
        sel_ovf = 1'b0;
        case (target)
            2'd0: begin
                cur_tap = pi_fine[lane];
                sel_ovf = pi_fineoverflow[lane];
            end
            2'd1: begin
                cur_tap = po_fine[lane];
                sel_ovf = po_fineoverflow[lane];
            end
            2'd2: begin
                cur_tap = {3'b000, po_coarse[lane]};
                cur_lim = COARSE_LIM;
                sel_ovf = po_coarseoverflow[lane];
            end
            default: ;
        endcase
        // A step that would leave the legal range is refused, never wrapped
        at_limit = inc ? (cur_tap >= cur_lim) : (cur_tap == 6'd0);
    end

    // Next-state decision and error detection
    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_next = CHECK;
            end
            CHECK: begin
                if (target == 2'd3) begin
                    err_set    = 1'b1;
                    state_next = FIN;
                end else if (issued == steps) begin
                    state_next = FIN;
                end else if (at_limit) begin
                    err_set    = 1'b1;
                    state_next = FIN;
                end else begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (sel_ovf) begin
                    err_set    = 1'b1;
                    state_next = FIN;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = CHECK;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle enable pulse on the selected lane/target; INC only alongside it
    always_comb begin
        lane_onehot       = '0;
        lane_onehot[lane] = 1'b1;
        pi_fineenable     = '0;
        po_fineenable     = '0;
        po_coarseenable   = '0;
        if (state == PULSE) begin
            case (target)
                2'd0:    pi_fineenable   = lane_onehot;
                2'd1:    po_fineenable   = lane_onehot;
                2'd2:    po_coarseenable = lane_onehot;
                default: ;
            endcase
        end
        pi_fineinc   = inc ? pi_fineenable   : '0;
        po_fineinc   = inc ? po_fineenable   : '0;
        po_coarseinc = inc ? po_coarseenable : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request latch, step/settle counters, shadow taps and completion status
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            target     <= '0;
            inc        <= 1'b0;
            steps      <= '0;
            issued     <= '0;
            err        <= 1'b0;
            settle_cnt <= '0;
            done_steps <= '0;
            done_err   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                pi_fine[i]   <= '0;
                po_fine[i]   <= '0;
                po_coarse[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane   <= req_lane;
                        target <= req_target;
                        inc    <= req_inc;
                        steps  <= req_steps;
                        issued <= '0;
                        err    <= 1'b0;
                    end
                end
                PULSE: begin
                    issued     <= issued + 6'd1;
                    settle_cnt <= '0;
                    case (target)
                        2'd0: pi_fine[lane]   <= inc ? pi_fine[lane] + 6'd1 : pi_fine[lane] - 6'd1;
                        2'd1: po_fine[lane]   <= inc ? po_fine[lane] + 6'd1 : po_fine[lane] - 6'd1;
                        2'd2: po_coarse[lane] <= inc ? po_coarse[lane] + 3'd1 : po_coarse[lane] - 3'd1;
                        default: ;
                    endcase
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SETTLE_ONE;
                end
                default: ;
            endcase
            if (err_set) err <= 1'b1;
            // Status is loaded on entry to FIN so it is already valid while DONE is high
            if ((state != FIN) && (state_next == FIN)) begin
                done_steps <= issued;
                done_err   <= err | err_set;
            end
        end
    end

endmodule

// File: tb/tb_phaser_tap_ctrl.sv
// tb_phaser_tap_ctrl: scoreboard bench for phaser_tap_ctrl with a tap-level
// reference model, directed scenarios and randomized step requests.
module tb_phaser_tap_ctrl;

    localparam int NL = 4;

    typedef struct {
        int steps;
        int err;
        int cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_lane;
    logic [1:0]    req_target;
    logic          req_inc;
    logic [5:0]    req_steps;
    logic          done;
    logic [5:0]    done_steps;
    logic          done_err;
    logic [NL-1:0] pi_en, pi_inc, po_en, po_inc, pc_en, pc_inc;
    logic [NL-1:0] pi_ovf, po_ovf, pc_ovf;
    logic [1:0]    rd_lane;
    logic [5:0]    rd_pi, rd_po;
    logic [2:0]    rd_pc;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   sh[3][NL];
    exp_t exp_q[$];
    int   cur_lane = 0, cur_target = 0, cur_inc = 0, cur_k = 0;
    int   last_steps = 0, last_err = 0;

    phaser_tap_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lane(req_lane),
        .req_target(req_target), .req_inc(req_inc), .req_steps(req_steps),
        .done(done), .done_steps(done_steps), .done_err(done_err),
        .pi_fineenable(pi_en), .pi_fineinc(pi_inc),
        .po_fineenable(po_en), .po_fineinc(po_inc),
        .po_coarseenable(pc_en), .po_coarseinc(pc_inc),
        .pi_fineoverflow(pi_ovf), .po_fineoverflow(po_ovf), .po_coarseoverflow(pc_ovf),
        .rd_lane(rd_lane), .rd_pi_fine(rd_pi), .rd_po_fine(rd_po), .rd_po_coarse(rd_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int lim(input int t);
        return (t == 2) ? 7 : 63;
    endfunction

    task automatic check_readback(input string tag);
        for (int l = 0; l < NL; l++) begin
            rd_lane = 2'(l);
            #1;
            chk({tag, "_rd_pi"}, rd_pi, sh[0][l]);
            chk({tag, "_rd_po"}, rd_po, sh[1][l]);
            chk({tag, "_rd_pc"}, rd_pc, sh[2][l]);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        while (!req_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // mode 0: plain request; 1: hold REQ_VALID with random fields while busy;
    // 2: assert RST during the third settle window
    task automatic do_req(input int l, input int t, input int i, input int s,
                          input int k, input int mode);
        int   room, n, iss, er, lat, d0;
        bit   ok;
        exp_t e;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        if (t == 3) begin
            iss = 0; er = 1; lat = 2;
        end else begin
            room = i ? (lim(t) - sh[t][l]) : sh[t][l];
            n = (s < room) ? s : room;
            if (k >= 1 && k <= n) begin
                iss = k; er = 1; lat = 10 * k - 6;
            end else begin
                iss = n; er = (s > room) ? 1 : 0; lat = 2 + 10 * n;
            end
            sh[t][l] += i ? iss : -iss;
        end
        cur_lane = l; cur_target = t; cur_inc = i; cur_k = k;
        e.steps = iss; e.err = er; e.cyc = cyc + lat;
        exp_q.push_back(e);
        last_steps = iss; last_err = er;
        req_valid = 1'b1; req_lane = 2'(l); req_target = 2'(t);
        req_inc = 1'(i); req_steps = 6'(s);
        @(posedge clk);
        #1;
        if (mode == 1) begin
            req_lane = 2'($urandom); req_target = 2'($urandom);
            req_inc = 1'($urandom); req_steps = 6'($urandom);
            @(negedge clk);
            for (int g = 0; g < 3000 && !req_ready; g++) begin
                req_lane = 2'($urandom); req_target = 2'($urandom);
                req_inc = 1'($urandom); req_steps = 6'($urandom);
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        if (mode == 2) begin
            repeat (25) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < NL; b++) sh[a][b] = 0;
            chk("rst_mid_ready", req_ready, 1);
            chk("rst_mid_done", done, 0);
            chk("rst_mid_en", {pi_en, po_en, pc_en}, 0);
            chk("rst_mid_inc", {pi_inc, po_inc, pc_inc}, 0);
            chk("rst_mid_steps", done_steps, 0);
            chk("rst_mid_err", done_err, 0);
            check_readback("rst_mid");
            d0 = done_cnt;
            repeat (60) @(negedge clk);
            chk("rst_mid_no_done", done_cnt, d0);
            return;
        end
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        chk("held_steps", done_steps, last_steps);
        chk("held_err", done_err, last_err);
        check_readback("rb");
    endtask

    // Monitor: pulse legality, overflow injection and DONE scoreboard
    initial begin
        logic [3*NL-1:0] en_all, inc_all, exp_en;
        logic [NL-1:0]   mask;
        int              pulse_cnt, last_pulse;
        bit              ovf_on;
        exp_t            e;
        pulse_cnt = 0; last_pulse = 0; ovf_on = 0;
        pi_ovf = '0; po_ovf = '0; pc_ovf = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                pulse_cnt = 0;
                ovf_on = 0;
            end
            en_all  = {pc_en, po_en, pi_en};
            inc_all = {pc_inc, po_inc, pi_inc};
            if (en_all != '0) begin
                chk("onehot", $countones(en_all), 1);
                if (exp_q.size() == 0) begin
                    chk("stray_pulse", en_all, 0);
                end else begin
                    exp_en = (3*NL)'(1) << (cur_target * NL + cur_lane);
                    chk("pulse_sel", en_all, exp_en);
                    chk("pulse_inc", inc_all, cur_inc ? exp_en : '0);
                    if (pulse_cnt > 0) chk("pulse_gap", cyc - last_pulse, 10);
                    last_pulse = cyc;
                    pulse_cnt++;
                    if (pulse_cnt == cur_k) ovf_on = 1;
                end
            end else if (inc_all != '0) begin
                chk("inc_without_en", inc_all, 0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_steps", done_steps, e.steps);
                    chk("done_err", done_err, e.err);
                    chk("done_cycle", cyc, e.cyc);
                    chk("pulse_count", pulse_cnt, e.steps);
                end
                pulse_cnt = 0;
                ovf_on = 0;
            end
            // Unselected lanes carry random overflow noise; the selected bit is
            // raised from the chosen pulse onward to hit that step's settle window
            mask = ~(NL'(1) << cur_lane);
            pi_ovf = NL'($urandom) & mask;
            po_ovf = NL'($urandom) & mask;
            pc_ovf = NL'($urandom) & mask;
            if (ovf_on) begin
                case (cur_target)
                    0: pi_ovf[cur_lane] = 1'b1;
                    1: po_ovf[cur_lane] = 1'b1;
                    2: pc_ovf[cur_lane] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Stimulus
    initial begin
        int l, t, i, s, k, m;
        rst = 1'b1; req_valid = 1'b0; req_lane = '0; req_target = '0;
        req_inc = 1'b0; req_steps = '0; rd_lane = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < NL; b++) sh[a][b] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", req_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_steps", done_steps, 0);
        chk("reset_err", done_err, 0);
        chk("reset_en", {pi_en, po_en, pc_en}, 0);
        chk("reset_inc", {pi_inc, po_inc, pc_inc}, 0);
        check_readback("reset");

        do_req(1, 0, 1, 5, 0, 0);   // PI fine inc 5
        do_req(0, 2, 1, 9, 0, 0);   // coarse runs into its limit after 7
        do_req(0, 2, 0, 2, 0, 0);   // back down to 5
        do_req(2, 1, 1, 4, 2, 0);   // overflow during the 2nd settle
        do_req(3, 0, 1, 0, 0, 0);   // zero steps
        do_req(1, 3, 1, 5, 0, 0);   // illegal target
        do_req(3, 1, 0, 3, 0, 0);   // decrement at zero
        do_req(1, 0, 1, 58, 0, 0);  // PI fine lane1 up to 63 exactly
        do_req(1, 0, 1, 1, 0, 0);   // increment at fine max
        do_req(3, 1, 1, 8, 0, 2);   // reset mid-sequence
        do_req(2, 0, 1, 3, 0, 1);   // busy-time request noise

        for (int n = 0; n < 40; n++) begin
            l = $urandom_range(0, NL - 1);
            t = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            i = $urandom_range(0, 1);
            s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            k = (s > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, s) : 0;
            m = ($urandom_range(0, 2) == 0) ? 1 : 0;
            do_req(l, t, i, s, k, m);
        end

        for (int g = 0; g < 2000 && exp_q.size() > 0; g++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
